deser400_phsel: RTL and testbench

Per-channel phase-tracking stage fed by `deser400_ctrl`. Takes an 8-tap oversampled data sample every clock, measures where data edges fall between taps over a window framed by `pd_trig`, reports the edge map as `xorsum`, and selects the tap farthest from the edges as the data sampling phase, `phsel`. Software can override the phase at any time through `phwrite`/`phdata`. One instance exists per deserializer channel (I..IV). Its `xorsum`/`phsel` outputs return to the control block's read registers 5 and 6.

---
 rtl/deser400_phsel_if.sv | 38 +++
 rtl/deser400_phsel.sv | 149 ++++++++++++++
 tb/tb_deser400_phsel.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/deser400_phsel_if.sv
// deser400_phsel_if
// Bundles the per-channel signals between deser400_ctrl (master) and one
// deser400_phsel instance (slave).
//   enable   : channel enable
//   sample   : 8 oversampled taps, sample[i] is tap i
//   pd_trig  : single-cycle window-boundary pulse
//   phenable : allow automatic phase updates
//   phwrite  : single-cycle manual phase load strobe
//   phdata   : manual phase value, bits [2:0] used
//   xorsum   : edge map of the last completed window
//   phsel    : current tap select, bit 3 always 0
//   dout     : recovered data bit
//   state    : debug view of the evaluation FSM (0=ACQ, 1=EVAL, 2=UPD)
// There is no valid/ready handshake here: sample is consumed every clock,
// and pd_trig/phwrite are one-cycle strobes acted on in the cycle they are
// high. There is no back-pressure.
interface deser400_phsel_if;
    logic       enable;
    logic [7:0] sample;
    logic       pd_trig;
    logic       phenable;
    logic       phwrite;
    logic [3:0] phdata;
    logic [7:0] xorsum;
    logic [3:0] phsel;
    logic       dout;
    logic [1:0] state;

    modport master (
        output enable, sample, pd_trig, phenable, phwrite, phdata,
        input  xorsum, phsel, dout, state
    );

    modport slave (
        input  enable, sample, pd_trig, phenable, phwrite, phdata,
        output xorsum, phsel, dout, state
    );
endinterface

// File: rtl/deser400_phsel.sv
// deser400_phsel
// Per-channel phase tracker. Registers the 8 tap samples, ORs the
// tap-to-tap edges over a window framed by pd_trig, publishes the window's
// edge map as xorsum and moves phsel to the tap farthest from the edges.
// Software may load phsel directly through phwrite/phdata.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : deser400_phsel_if.slave (see the interface for the signal list)
// Optional feature: define DESER400_PHSEL_FILTER_EN to require two
// consecutive valid windows with the same candidate before committing.
module deser400_phsel (
    input  logic                   clk,
    input  logic                   reset,
    deser400_phsel_if.slave        bus
);

    typedef enum logic [1:0] {
        ACQ  = 2'd0,
        EVAL = 2'd1,
        UPD  = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] s_q;
    logic [7:0] acc;
    logic [7:0] edge_v;
    logic [7:0] xorsum_q;
    logic [2:0] phsel_q;
    logic       dout_q;
    logic [2:0] cand;
    logic       cand_v;
    logic       trig;
    logic       cls_v;
    logic [2:0] cls_e;
    logic       commit;
    logic       unused_phdata;

`ifdef DESER400_PHSEL_FILTER_EN
    logic [2:0] hist;
    logic       hist_v;
`endif

    // A disabled channel ignores window boundaries entirely.
    assign trig = bus.pd_trig & bus.enable;

    // edge_v[i] flags a transition between tap i and tap i+1 (tap 7 wraps to 0).
    assign edge_v = s_q ^ {s_q[0], s_q[7:1]};

    // Bit 3 of phdata carries no meaning.
    assign unused_phdata = bus.phdata[3];

    // A window is usable when it shows one edge, or two edges on adjacent
    // boundaries (7 and 0 are adjacent). e is the lower boundary in cyclic
    // order, so {7,0} gives e = 7.
    always_comb begin
        cls_v = 1'b0;
        cls_e = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((xorsum_q == (8'd1 << i)) ||
                (xorsum_q == ((8'd1 << i) | (8'd1 << ((i + 1) % 8))))) begin
                cls_v = 1'b1;
                cls_e = 3'(i);
            end
        end
    end

`ifdef DESER400_PHSEL_FILTER_EN
    // Commit only if the previous valid window proposed the same tap.
    assign commit = cand_v & hist_v & (hist == cand);
`else
    assign commit = cand_v;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_q      <= '0;
            acc      <= '0;
            xorsum_q <= '0;
            phsel_q  <= '0;
            dout_q   <= 1'b0;
            cand     <= '0;
            cand_v   <= 1'b0;
            state    <= ACQ;
`ifdef DESER400_PHSEL_FILTER_EN
            hist     <= '0;
            hist_v   <= 1'b0;
`endif
        end else begin
            s_q    <= bus.sample;
            dout_q <= bus.enable ? s_q[phsel_q] : 1'b0;

            // The edge seen in the pd_trig cycle still belongs to the closing window.
            if (!bus.enable) begin
                acc <= '0;
            end else if (bus.pd_trig) begin
                xorsum_q <= acc | edge_v;
                acc      <= '0;
            end else begin
                acc <= acc | edge_v;
            end

            case (state)
                ACQ: begin
                    if (trig) begin
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    // Five taps past the edge is the eye centre (half a bit
                    // is four taps, plus one because e names the boundary
                    // below the transition).
                    cand   <= cls_e + 3'd5;
                    cand_v <= cls_v;
                    state  <= UPD;
                end
                UPD: begin
                    state <= ACQ;
                end
                default: begin
                    state <= ACQ;
                end
            endcase

            // Manual load overrides a same-cycle automatic update.
            if (bus.phwrite) begin
                phsel_q <= bus.phdata[2:0];
`ifdef DESER400_PHSEL_FILTER_EN
                hist_v  <= 1'b0;
`endif
            end else if (state == UPD) begin
                if (commit && bus.phenable && bus.enable) begin
                    phsel_q <= cand;
                end
`ifdef DESER400_PHSEL_FILTER_EN
                // An invalid window wipes the history.
                hist   <= cand;
                hist_v <= cand_v;
`endif
            end
        end
    end

    assign bus.xorsum = xorsum_q;
    assign bus.phsel  = {1'b0, phsel_q};
    assign bus.dout   = dout_q;
    assign bus.state  = state;

endmodule

// File: tb/tb_deser400_phsel.sv
module tb_deser400_phsel;

    logic clk;
    logic reset;

    deser400_phsel_if bus ();

    deser400_phsel dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Expected outputs per clock as {xorsum, phsel, dout}.
    logic [12:0] exp_q[$];

    logic [7:0] m_sq, m_acc, m_xs;
    logic [2:0] m_ph, m_pend, m_hist;
    logic       m_pend_v, m_hist_v, m_dout;
    int         m_busy;  // clocks until the pending window decision applies

    // Returns {valid, candidate tap} for a window edge map.
    function automatic logic [3:0] classify(input logic [7:0] x);
        int n;
        logic [3:0] r;
        n = $countones(x);
        r = 4'd0;
        for (int i = 0; i < 8; i++)
            if (x[i] && (n == 1 || (n == 2 && x[(i + 1) % 8])))
                r = {1'b1, 3'((i + 5) % 8)};
        return r;
    endfunction

    task automatic model_step();
        logic [7:0] ev;
        logic [3:0] c;
        logic       ok;
        if (reset) begin
            m_sq = 0; m_acc = 0; m_xs = 0; m_ph = 0; m_dout = 0;
            m_pend = 0; m_pend_v = 0; m_hist = 0; m_hist_v = 0; m_busy = 0;
        end else begin
            for (int i = 0; i < 8; i++) ev[i] = (m_sq[i] != m_sq[(i + 1) % 8]);
            m_dout = bus.enable ? m_sq[m_ph] : 1'b0;
            if (m_busy == 1) begin
                ok = m_pend_v;
`ifdef DESER400_PHSEL_FILTER_EN
                ok = m_pend_v && m_hist_v && (m_hist == m_pend);
                m_hist   = m_pend;
                m_hist_v = m_pend_v;
`endif
                if (ok && bus.phenable && bus.enable) m_ph = m_pend;
            end
            if (bus.phwrite) begin
                m_ph = bus.phdata[2:0];
                m_hist_v = 0;
            end
            if (bus.pd_trig && bus.enable) begin
                m_xs = m_acc | ev;
                if (m_busy == 0) begin
                    c = classify(m_xs);
                    m_pend_v = c[3];
                    m_pend   = c[2:0];
                    m_busy   = 3;  // decremented below to 2
                end
            end
            if (m_busy > 0) m_busy--;
            if (!bus.enable) m_acc = 0;
            else if (bus.pd_trig) m_acc = 0;
            else m_acc = m_acc | ev;
            m_sq = bus.sample;
        end
        exp_q.push_back({m_xs, 1'b0, m_ph, m_dout});
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        logic [12:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("xorsum", {24'd0, bus.xorsum}, {24'd0, e[12:5]});
            check("phsel",  {28'd0, bus.phsel},  {28'd0, e[4:1]});
            check("dout",   {31'd0, bus.dout},   {31'd0, e[0]});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
        bus.pd_trig = 1'b0;
        bus.phwrite = 1'b0;
    endtask

    // len-1 plain cycles, a pd_trig cycle, then wait until a decision is visible.
    task automatic run_window(input int len);
        repeat (len - 1) tick();
        bus.pd_trig = 1'b1;
        tick();
        tick();
        tick();
    endtask

    task automatic toggle_window(input logic [7:0] a, input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            bus.sample = (i % 2 == 0) ? a : b;
            repeat (8) tick();
        end
        bus.pd_trig = 1'b1;
        tick();
        tick();
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset        = 1'b1;
        bus.enable   = 1'b1;
        bus.sample   = 8'h0F;
        bus.pd_trig  = 1'b0;
        bus.phenable = 1'b1;
        bus.phwrite  = 1'b0;
        bus.phdata   = 4'h0;
        tick();
        tick();
        check("rst_xorsum", {24'd0, bus.xorsum}, 32'h0);
        check("rst_phsel",  {28'd0, bus.phsel},  32'h0);
        check("rst_dout",   {31'd0, bus.dout},   32'h0);
        reset = 1'b0;

        // Constant 0F: edges on boundaries 3 and 7, not adjacent -> invalid.
        run_window(32);
        run_window(32);
        check("const0f_xorsum", {24'd0, bus.xorsum}, 32'h88);
        check("const0f_phsel",  {28'd0, bus.phsel},  32'h0);

        // 0F/F0 alternation produces the same boundaries.
        toggle_window(8'h0F, 8'hF0, 4);
        check("alt_xorsum", {24'd0, bus.xorsum}, 32'h88);
        check("alt_phsel",  {28'd0, bus.phsel},  32'h0);

        // 07/F8: boundaries 2 and 7, still invalid. First window is mixed.
        toggle_window(8'h07, 8'hF8, 4);
        toggle_window(8'h07, 8'hF8, 4);
        check("07f8_xorsum", {24'd0, bus.xorsum}, 32'h84);
        check("07f8_phsel",  {28'd0, bus.phsel},  32'h0);

        // Isolated tap 0: edges {7,0} -> e=7 -> tap 4. Two clean windows
        // so the result holds with or without the filter.
        bus.sample = 8'h01;
        run_window(20);
        run_window(20);
        run_window(20);
        check("pair70_xorsum", {24'd0, bus.xorsum}, 32'h81);
        check("pair70_phsel",  {28'd0, bus.phsel},  32'h4);

        // Manual load, bit 3 ignored.
        bus.phwrite = 1'b1;
        bus.phdata  = 4'hD;
        tick();
        check("phwrite_phsel", {28'd0, bus.phsel}, 32'h5);

        // Manual load in the UPD cycle beats the automatic candidate (4).
        repeat (10) tick();
        bus.pd_trig = 1'b1;
        tick();
        tick();
        bus.phwrite = 1'b1;
        bus.phdata  = 4'h2;
        tick();
        check("phwrite_upd_phsel", {28'd0, bus.phsel}, 32'h2);

        // Disabled channel: dout forced low, xorsum frozen despite pd_trig.
        bus.enable = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.sample  = 8'($urandom_range(0, 255));
            bus.pd_trig = (i % 4 == 3);
            tick();
        end
        check("dis_dout",   {31'd0, bus.dout},   32'h0);
        check("dis_xorsum", {24'd0, bus.xorsum}, 32'h81);
        check("dis_phsel",  {28'd0, bus.phsel},  32'h2);
        bus.enable = 1'b1;
        bus.sample = 8'h01;

        // Reset between pd_trig and UPD discards the pending update.
        repeat (10) tick();
        bus.pd_trig = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_xorsum", {24'd0, bus.xorsum}, 32'h0);
        check("midrst_phsel",  {28'd0, bus.phsel},  32'h0);
        check("midrst_dout",   {31'd0, bus.dout},   32'h0);
        repeat (5) tick();
        check("midrst_noupd_phsel", {28'd0, bus.phsel}, 32'h0);

        // Randomized windows against the model.
        for (int w = 0; w < 60; w++) begin
            int typ, k, len, pw_at;
            logic [7:0] base;
            typ = $urandom_range(0, 3);
            k   = $urandom_range(0, 7);
            case (typ)
                0:       base = 8'd1 << k;
                1:       base = ~(8'd1 << k);
                2:       base = 8'($urandom_range(0, 255));
                default: base = 8'd1 << k;
            endcase
            bus.phenable = ($urandom_range(0, 7) != 0);
            bus.enable   = ($urandom_range(0, 11) != 0);
            len   = $urandom_range(6, 30);
            pw_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            for (int c = 0; c < len; c++) begin
                bus.sample = (typ == 3 && (c % 2) == 1) ? ~base : base;
                if (c == pw_at) begin
                    bus.phwrite = 1'b1;
                    bus.phdata  = 4'($urandom_range(0, 15));
                end
                if ($urandom_range(0, 24) == 0) bus.pd_trig = 1'b1;
                tick();
            end
            bus.pd_trig = 1'b1;
            tick();
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1;
                tick();
                tick();
                reset = 1'b0;
            end
        end
        bus.enable = 1'b1;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
